// File: rtl/apb4_slave_pkg.sv
// Shared types and helpers for the APB4 slave front-end of the TWI register block.
package apb4_slave_pkg;

    // Width used for address arithmetic inside the decode helpers
    localparam int unsigned ADDR_CALC_W = 32;

    // Transfer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Why the current/last transfer errored, kept for debug visibility
    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ALIGN   = 3'd1,
        ERR_RANGE   = 3'd2,
        ERR_STRB    = 3'd3,
        ERR_BACKEND = 3'd4,
        ERR_TIMEOUT = 3'd5
    } err_cause_e;

    // Word index of a byte address for a bus of strb_width byte lanes
    function automatic logic [ADDR_CALC_W-1:0] word_index(
        input logic [ADDR_CALC_W-1:0] byte_addr,
        input int unsigned            strb_width
    );
        return byte_addr >> $clog2(strb_width);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Loadable up-counter bounding the number of wait states of one transfer.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc_c
);

    logic [CNT_W-1:0] count;

    // Clear wins over load, load wins over increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal count: last wait cycle before a forced timeout
    assign tc_c = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb4_slave_if.sv
// APB4 slave front-end: decodes/validates a transfer, strobes the backend once,
// then holds the bus until the backend completes or the wait timer expires.
module apb4_slave_if
    import apb4_slave_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 8,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH     = APB_DATA_WIDTH / 8,
    parameter int unsigned NUM_REGS       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [APB_DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0]     pstrb,
    output logic [APB_DATA_WIDTH-1:0] prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      wr_en,
    output logic                      rd_en,
    output logic [APB_ADDR_WIDTH-1:0] addr,
    output logic [APB_DATA_WIDTH-1:0] wr_data,
    output logic [STRB_WIDTH-1:0]     wr_strb,
    input  logic                      be_ready,
    input  logic [APB_DATA_WIDTH-1:0] rd_data,
    input  logic                      be_err
);

    localparam int unsigned            TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDR_CALC_W-1:0] ALIGN_MASK = ADDR_CALC_W'(STRB_WIDTH - 1);

    state_e     state;
    err_cause_e pend_cause;
    err_cause_e setup_cause_c;
    logic       is_write;
    logic       setup_c;
    logic       timer_tc_c;

    assign setup_c = psel & ~penable;

    // Validate the setup-phase request before anything reaches the backend
    always_comb begin
        setup_cause_c = ERR_NONE;
        if ((ADDR_CALC_W'(paddr) & ALIGN_MASK) != '0) begin
            setup_cause_c = ERR_ALIGN;
        end else if (word_index(ADDR_CALC_W'(paddr), STRB_WIDTH) >= ADDR_CALC_W'(NUM_REGS)) begin
            setup_cause_c = ERR_RANGE;
        end else if (!pwrite && (pstrb != '0)) begin
            setup_cause_c = ERR_STRB;
        end
    end

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (TIMER_W)
    ) u_timer (
        .clk      (pclk),
        .rst      (preset),
        .clr      ((state == WAIT) && !psel),
        .load     ((state == IDLE) && setup_c),
        .load_val (TIMER_W'(0)),
        .en       (state == WAIT),
        .tc_c     (timer_tc_c)
    );

    // Transfer FSM with registered bus and backend outputs. Rejected transfers
    // still pass through one WAIT cycle (without strobing) so that every
    // response, good or bad, lands no earlier than the second cycle.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            pend_cause <= ERR_NONE;
            is_write   <= 1'b0;
            prdata     <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            addr       <= '0;
            wr_data    <= '0;
            wr_strb    <= '0;
        end else begin
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            case (state)
                IDLE: begin
                    if (setup_c) begin
                        addr       <= paddr;
                        wr_data    <= pwdata;
                        wr_strb    <= pstrb;
                        is_write   <= pwrite;
                        pend_cause <= setup_cause_c;
                        state      <= WAIT;
                        if (setup_cause_c == ERR_NONE) begin
                            wr_en <= pwrite;
                            rd_en <= ~pwrite;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state      <= IDLE;
                        pend_cause <= ERR_NONE;
                    end else if (pend_cause != ERR_NONE) begin
                        state   <= RESP;
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        prdata  <= '0;
                    end else if (be_ready) begin
                        state      <= RESP;
                        pready     <= 1'b1;
                        pslverr    <= be_err;
                        prdata     <= is_write ? '0 : rd_data;
                        pend_cause <= be_err ? ERR_BACKEND : ERR_NONE;
                    end else if (timer_tc_c) begin
                        state      <= RESP;
                        pready     <= 1'b1;
                        pslverr    <= 1'b1;
                        prdata     <= '0;
                        pend_cause <= ERR_TIMEOUT;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_slave_if.sv
// Directed self-checking bench for apb4_slave_if.
module tb_apb4_slave_if;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned NRG = 8;
    localparam int unsigned TMO = 16;

    logic          pclk = 1'b0;
    logic          preset;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          be_ready;
    logic [DW-1:0] rd_data;
    logic          be_err;

    int n_cmp = 0;
    int n_err = 0;

    apb4_slave_if #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .STRB_WIDTH     (SW),
        .NUM_REGS       (NRG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .be_ready (be_ready),
        .rd_data  (rd_data),
        .be_err   (be_err)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Drives one APB transfer plus a backend answering `delay` cycles after the
    // strobe (delay < 0: never). lat is the cycle index of pready (setup = 0).
    task automatic apb_xfer(
        input  logic          wr,
        input  logic [AW-1:0] a,
        input  logic [DW-1:0] d,
        input  logic [SW-1:0] s,
        input  int            delay,
        input  logic          err,
        input  logic [DW-1:0] rdat,
        output int            lat,
        output int            nwr,
        output int            nrd,
        output logic [AW-1:0] s_addr,
        output logic [SW-1:0] s_strb,
        output logic [DW-1:0] s_wdata,
        output logic [DW-1:0] rdata,
        output logic          slverr
    );
        int   strobe_at;
        int   c;
        logic done;
        lat = 0; nwr = 0; nrd = 0; strobe_at = -1; done = 1'b0;
        s_addr = '0; s_strb = '0; s_wdata = '0; rdata = '0; slverr = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        be_ready = 1'b0; be_err = 1'b0; rd_data = '0;
        tick();
        penable = 1'b1;
        c = 1;
        while (!done && c <= 40) begin
            if (wr_en) nwr++;
            if (rd_en) nrd++;
            if ((wr_en || rd_en) && strobe_at < 0) begin
                strobe_at = c;
                s_addr = addr; s_strb = wr_strb; s_wdata = wr_data;
            end
            if (pready) begin
                lat = c; rdata = prdata; slverr = pslverr;
                be_ready = 1'b0;
                done = 1'b1;
            end else begin
                if (delay >= 0 && strobe_at >= 0 && (c - strobe_at) >= delay) begin
                    be_ready = 1'b1; be_err = err; rd_data = rdat;
                end else begin
                    be_ready = 1'b0;
                end
                tick();
                c++;
            end
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL xfer_timeout addr=%0h: no pready within 40 cycles", a);
        end
        tick();
        psel = 1'b0; penable = 1'b0; be_ready = 1'b0; be_err = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; be_ready = 1'b0; rd_data = '0; be_err = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({pready, pslverr, wr_en, rd_en} !== 4'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {pready, pslverr, wr_en, rd_en});
        end
        n_cmp++;
        if (prdata !== 32'h0) begin
            n_err++; $display("FAIL reset_prdata: got %0h expected 0", prdata);
        end
        n_cmp++;
        if ({addr, wr_data, wr_strb} !== '0) begin
            n_err++; $display("FAIL reset_latches: got %0h/%0h/%0h expected 0", addr, wr_data, wr_strb);
        end
        preset = 1'b0;
        tick();
    endtask

    task automatic test_write_basic();
        int lat, nwr, nrd; logic [AW-1:0] sa; logic [SW-1:0] ss; logic [DW-1:0] sd, rd; logic se;
        apb_xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (nwr !== 1 || nrd !== 0) begin n_err++; $display("FAIL wr_strobes: got wr=%0d rd=%0d expected 1/0", nwr, nrd); end
        n_cmp++; if (sa !== 8'h04 || ss !== 4'hF) begin n_err++; $display("FAIL wr_addr_strb: got %0h/%0h expected 4/f", sa, ss); end
        n_cmp++; if (sd !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_data: got %0h expected deadbeef", sd); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        n_cmp++; if (se !== 1'b0 || rd !== 32'h0) begin n_err++; $display("FAIL wr_resp: got err=%b prdata=%0h expected 0/0", se, rd); end
    endtask

    task automatic test_read_wait();
        int lat, nwr, nrd; logic [AW-1:0] sa; logic [SW-1:0] ss; logic [DW-1:0] sd, rd; logic se;
        apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, 3, 1'b0, 32'h12345678, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (nrd !== 1 || nwr !== 0 || sa !== 8'h08) begin n_err++; $display("FAIL rd_strobe: got rd=%0d wr=%0d addr=%0h expected 1/0/8", nrd, nwr, sa); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL rd_latency: got %0d expected 5", lat); end
        n_cmp++; if (rd !== 32'h12345678 || se !== 1'b0) begin n_err++; $display("FAIL rd_data: got %0h err=%b expected 12345678/0", rd, se); end
    endtask

    task automatic test_decode_err();
        int lat, nwr, nrd; logic [AW-1:0] sa; logic [SW-1:0] ss; logic [DW-1:0] sd, rd; logic se;
        apb_xfer(1'b0, 8'h20, 32'h0, 4'h0, 0, 1'b0, 32'h77777777, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (nwr + nrd !== 0) begin n_err++; $display("FAIL range_nostrobe: got %0d strobes expected 0", nwr + nrd); end
        n_cmp++; if (lat !== 2 || se !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL range_resp: got lat=%0d err=%b prdata=%0h expected 2/1/0", lat, se, rd); end
        apb_xfer(1'b1, 8'h05, 32'h11111111, 4'hF, 0, 1'b0, 32'h0, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (nwr + nrd !== 0) begin n_err++; $display("FAIL align_nostrobe: got %0d strobes expected 0", nwr + nrd); end
        n_cmp++; if (lat !== 2 || se !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL align_resp: got lat=%0d err=%b prdata=%0h expected 2/1/0", lat, se, rd); end
    endtask

    task automatic test_strobe_rules();
        int lat, nwr, nrd; logic [AW-1:0] sa; logic [SW-1:0] ss; logic [DW-1:0] sd, rd; logic se;
        apb_xfer(1'b0, 8'h00, 32'h0, 4'h1, 0, 1'b0, 32'h0, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (nrd !== 0 || se !== 1'b1 || lat !== 2) begin n_err++; $display("FAIL rd_pstrb_err: got rd=%0d err=%b lat=%0d expected 0/1/2", nrd, se, lat); end
        apb_xfer(1'b1, 8'h10, 32'h00000055, 4'h0, 0, 1'b0, 32'h0, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (nwr !== 1 || ss !== 4'h0 || sa !== 8'h10) begin n_err++; $display("FAIL wr_zero_strb: got wr=%0d strb=%0h addr=%0h expected 1/0/10", nwr, ss, sa); end
        n_cmp++; if (se !== 1'b0 || lat !== 2) begin n_err++; $display("FAIL wr_zero_strb_resp: got err=%b lat=%0d expected 0/2", se, lat); end
    endtask

    task automatic test_timeout_be_err();
        int lat, nwr, nrd; logic [AW-1:0] sa; logic [SW-1:0] ss; logic [DW-1:0] sd, rd; logic se;
        apb_xfer(1'b1, 8'h14, 32'h0000ABCD, 4'hF, -1, 1'b0, 32'h0, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (nwr !== 1) begin n_err++; $display("FAIL tmo_strobe: got %0d expected 1", nwr); end
        n_cmp++; if (lat !== TMO + 1 || se !== 1'b1) begin n_err++; $display("FAIL tmo_resp: got lat=%0d err=%b expected %0d/1", lat, se, TMO + 1); end
        apb_xfer(1'b1, 8'h18, 32'h0000BEEF, 4'h3, 2, 1'b1, 32'h0, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (lat !== 4 || se !== 1'b1) begin n_err++; $display("FAIL be_err_resp: got lat=%0d err=%b expected 4/1", lat, se); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0C; pwdata = '0; pstrb = '0; be_ready = 1'b0;
        tick();
        penable = 1'b1;
        n_cmp++; if (rd_en !== 1'b1) begin n_err++; $display("FAIL mid_rd_en: got %b expected 1", rd_en); end
        preset = 1'b1;
        tick();
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        n_cmp++;
        if ({pready, pslverr, wr_en, rd_en} !== 4'b0 || addr !== '0 || prdata !== '0) begin
            n_err++; $display("FAIL mid_reset_outs: got ctrl=%b addr=%0h prdata=%0h expected 0", {pready, pslverr, wr_en, rd_en}, addr, prdata);
        end
        be_ready = 1'b1; rd_data = 32'hFFFFFFFF;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | pready | pslverr | wr_en | rd_en | (prdata != '0);
        end
        be_ready = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_late_ready: got activity=%b expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat, nwr, nrd; logic [AW-1:0] sa; logic [SW-1:0] ss; logic [DW-1:0] sd, rd; logic se;
        apb_xfer(1'b1, 8'h0C, 32'hA5A50F0F, 4'h3, 0, 1'b0, 32'h0, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (nwr !== 1 || sa !== 8'h0C || ss !== 4'h3 || sd !== 32'hA5A50F0F) begin
            n_err++; $display("FAIL b2b_wr: got wr=%0d addr=%0h strb=%0h data=%0h expected 1/c/3/a5a50f0f", nwr, sa, ss, sd);
        end
        n_cmp++; if (lat !== 2 || se !== 1'b0) begin n_err++; $display("FAIL b2b_wr_resp: got lat=%0d err=%b expected 2/0", lat, se); end
        apb_xfer(1'b0, 8'h1C, 32'h0, 4'h0, 1, 1'b0, 32'hCAFEF00D, lat, nwr, nrd, sa, ss, sd, rd, se);
        n_cmp++; if (nrd !== 1 || sa !== 8'h1C) begin n_err++; $display("FAIL b2b_rd: got rd=%0d addr=%0h expected 1/1c", nrd, sa); end
        n_cmp++; if (lat !== 3 || rd !== 32'hCAFEF00D || se !== 1'b0) begin
            n_err++; $display("FAIL b2b_rd_resp: got lat=%0d prdata=%0h err=%b expected 3/cafef00d/0", lat, rd, se);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_decode_err();
        test_strobe_rules();
        test_timeout_be_err();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
